// File: rtl/fifo_tg_pkg.sv
// Shared types and helpers for the fifo traffic generator: FSM state encoding
// and the saturating error-count increment.
package fifo_tg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } tg_state_t;

    localparam int ERR_CNT_W = 8;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_traffic_gen_if.sv
// Push/pop bus between the traffic generator (master) and the fifo (slave).
interface fifo_traffic_gen_if #(
    parameter int WIDTH = 8
) ();

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] data_out;

    modport master (output push, output pop, output data_in,
                    input  full, input  empty, input  data_out);

    modport slave  (input  push, input  pop, input  data_in,
                    output full, output empty, output data_out);

endinterface

// File: rtl/fifo_tg_checker.sv
// Read-side checker: compares each popped word with the expected sequence and
// keeps sticky mismatch status across rounds.
module fifo_tg_checker
    import fifo_tg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pop_en,
    input  logic [WIDTH-1:0]     data_out,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [WIDTH-1:0]     rd_seq_r;
    logic                 err_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    // Expected-sequence tracking and sticky mismatch capture on every pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_seq_r  <= {WIDTH{1'b0}};
            err_r     <= 1'b0;
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (pop_en) begin
            // The sequence advances even on a mismatch so one bad word costs one count
            rd_seq_r <= rd_seq_r + WIDTH'(1);
            if (data_out != rd_seq_r) begin
                err_r     <= 1'b1;
                err_cnt_r <= sat_inc(err_cnt_r);
            end
        end
    end

    assign err     = err_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: rtl/fifo_traffic_gen.sv
// Fifo traffic generator: pushes an incrementing sequence, drains a programmed
// number of words and checks them, clipping bursts against tracked occupancy.
module fifo_traffic_gen
    import fifo_tg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int LEN_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      push_len,
    input  logic [LEN_W-1:0]      pop_len,
    fifo_traffic_gen_if.master    fifo_bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int TGT_W = (LEN_W > OCC_W) ? LEN_W : OCC_W;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    function automatic logic [TGT_W-1:0] clip_tgt(input logic [TGT_W-1:0] req,
                                                  input logic [TGT_W-1:0] lim);
        return (req < lim) ? req : lim;
    endfunction

    tg_state_t        state_r;
    tg_state_t        state_s;
    logic             push_s;
    logic             pop_s;
    logic [LEN_W-1:0] pop_len_r;
    logic [TGT_W-1:0] push_tgt_r;
    logic [TGT_W-1:0] pop_tgt_r;
    logic [TGT_W-1:0] push_cnt_r;
    logic [TGT_W-1:0] pop_cnt_r;
    logic [WIDTH-1:0] wr_seq_r;
    logic [OCC_W-1:0] occ_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and strobes; a phase ends the cycle after its count is met
    always_comb begin
        state_s = state_r;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (push_cnt_r >= push_tgt_r) begin
                    state_s = ST_DRAIN;
                end else begin
                    push_s = !fifo_bus.full;
                end
            end
            ST_DRAIN: begin
                if (pop_cnt_r >= pop_tgt_r) begin
                    state_s = ST_DONE;
                end else begin
                    pop_s = !fifo_bus.empty;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Burst targets and per-round counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_len_r  <= {LEN_W{1'b0}};
            push_tgt_r <= {TGT_W{1'b0}};
            pop_tgt_r  <= {TGT_W{1'b0}};
            push_cnt_r <= {TGT_W{1'b0}};
            pop_cnt_r  <= {TGT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        push_tgt_r <= clip_tgt(TGT_W'(push_len), TGT_W'(DEPTH_OCC - occ_r));
                        pop_len_r  <= pop_len;
                    end
                    push_cnt_r <= {TGT_W{1'b0}};
                    pop_cnt_r  <= {TGT_W{1'b0}};
                end
                ST_FILL: begin
                    if (push_s) begin
                        push_cnt_r <= push_cnt_r + TGT_W'(1);
                    end
                    // occ_r is final here because no push happens on the exit cycle
                    if (push_cnt_r >= push_tgt_r) begin
                        pop_tgt_r <= clip_tgt(TGT_W'(pop_len_r), TGT_W'(occ_r));
                    end
                end
                ST_DRAIN: begin
                    if (pop_s) begin
                        pop_cnt_r <= pop_cnt_r + TGT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Write sequence and occupancy persist across rounds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_seq_r <= {WIDTH{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
        end else if (push_s) begin
            wr_seq_r <= wr_seq_r + WIDTH'(1);
            occ_r    <= occ_r + OCC_W'(1);
        end else if (pop_s) begin
            occ_r    <= occ_r - OCC_W'(1);
        end
    end

    fifo_tg_checker #(
        .WIDTH (WIDTH)
    ) u_checker (
        .clk      (clk),
        .rst_n    (rst_n),
        .pop_en   (pop_s),
        .data_out (fifo_bus.data_out),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    assign fifo_bus.push    = push_s;
    assign fifo_bus.pop     = pop_s;
    assign fifo_bus.data_in = wr_seq_r;
    assign busy             = (state_r != ST_IDLE);
    assign done             = (state_r == ST_DONE);

endmodule
